// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access stage between the EX/MEM register and write-back.
// Issues loads/stores over a req/ack handshake to a variable-latency memory,
// stalls upstream while an access is outstanding, resolves taken branches and
// records memory timeouts in a sticky error flag.
module mem_wb_stage #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] PC_in,
  input  logic [63:0] aluResult_in,
  input  logic [63:0] data2_in,
  input  logic [4:0]  rd_in,
  input  logic        Branch_in,
  input  logic        MemRead_in,
  input  logic        MemtoReg_in,
  input  logic        MemWrite_in,
  input  logic        RegWrite_in,
  input  logic        zero_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        stall,
  output logic        PCSrc,
  output logic [63:0] branch_target,
  output logic [63:0] readData_out,
  output logic [63:0] aluResult_out,
  output logic [4:0]  rd_out,
  output logic        MemtoReg_out,
  output logic        RegWrite_out,
  output logic        mem_err
);

  typedef enum logic {IDLE, REQ} state_t;

  // Last REQ cycle index; the counter saturates here and never wraps.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [4:0]  rd_q;
  logic        memtoreg_q;
  logic        regwrite_q;
  logic        is_write_q;

  logic [63:0] readData_q;
  logic [63:0] aluResult_q;
  logic [4:0]  rdout_q;
  logic        memtoregout_q;
  logic        regwriteout_q;
  logic        err_q;

  logic mem_op;
  logic timeout;

  assign mem_op  = MemRead_in | MemWrite_in;
  assign timeout = (state_q == REQ) && (cnt_q == TO_LAST);

  // Handshake, stall and branch resolution derived from the current state.
  always_comb begin
    mem_req       = (state_q == REQ);
    mem_we        = (state_q == REQ) & is_write_q;
    mem_addr      = addr_q;
    mem_wdata     = wdata_q;
    branch_target = PC_in;
    PCSrc         = Branch_in & zero_in & (state_q == IDLE);
    // Upstream must not be frozen while reset is asserted.
    if (reset)
      stall = 1'b0;
    else if (state_q == IDLE)
      stall = mem_op;
    else
      stall = ~mem_ack & ~timeout;
  end

  assign readData_out  = readData_q;
  assign aluResult_out = aluResult_q;
  assign rd_out        = rdout_q;
  assign MemtoReg_out  = memtoregout_q;
  assign RegWrite_out  = regwriteout_q;
  assign mem_err       = err_q;

  // Access FSM, hold registers and MEM/WB output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      readData_q    <= '0;
      aluResult_q   <= '0;
      rdout_q       <= '0;
      memtoregout_q <= 1'b0;
      regwriteout_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_op) begin
            addr_q        <= aluResult_in;
            wdata_q       <= data2_in;
            rd_q          <= rd_in;
            memtoreg_q    <= MemtoReg_in;
            regwrite_q    <= RegWrite_in;
            is_write_q    <= MemWrite_in;
            cnt_q         <= '0;
            state_q       <= REQ;
            readData_q    <= '0;
            aluResult_q   <= '0;
            rdout_q       <= '0;
            memtoregout_q <= 1'b0;
            regwriteout_q <= 1'b0;
          end else begin
            readData_q    <= '0;
            aluResult_q   <= aluResult_in;
            rdout_q       <= rd_in;
            memtoregout_q <= MemtoReg_in;
            regwriteout_q <= RegWrite_in;
          end
        end
        REQ: begin
          if (mem_ack) begin
            readData_q    <= is_write_q ? 64'd0 : mem_rdata;
            aluResult_q   <= addr_q;
            rdout_q       <= rd_q;
            memtoregout_q <= memtoreg_q;
            regwriteout_q <= regwrite_q;
            state_q       <= IDLE;
          end else if (timeout) begin
            err_q         <= 1'b1;
            readData_q    <= '0;
            aluResult_q   <= '0;
            rdout_q       <= '0;
            memtoregout_q <= 1'b0;
            regwriteout_q <= 1'b0;
            state_q       <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed testbench for mem_wb_stage with hand-computed expectations.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] PC_in, aluResult_in, data2_in, mem_rdata;
  logic [4:0]  rd_in;
  logic        Branch_in, MemRead_in, MemtoReg_in, MemWrite_in, RegWrite_in, zero_in, mem_ack;
  logic        mem_req, mem_we, stall, PCSrc, MemtoReg_out, RegWrite_out, mem_err;
  logic [63:0] mem_addr, mem_wdata, branch_target, readData_out, aluResult_out;
  logic [4:0]  rd_out;

  int n_cmp = 0;
  int n_bad = 0;
  int n;

  always #5 clk = ~clk;

  mem_wb_stage #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .reset(reset), .PC_in(PC_in), .aluResult_in(aluResult_in),
    .data2_in(data2_in), .rd_in(rd_in), .Branch_in(Branch_in),
    .MemRead_in(MemRead_in), .MemtoReg_in(MemtoReg_in), .MemWrite_in(MemWrite_in),
    .RegWrite_in(RegWrite_in), .zero_in(zero_in), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall), .PCSrc(PCSrc),
    .branch_target(branch_target), .readData_out(readData_out),
    .aluResult_out(aluResult_out), .rd_out(rd_out), .MemtoReg_out(MemtoReg_out),
    .RegWrite_out(RegWrite_out), .mem_err(mem_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    PC_in = '0; aluResult_in = '0; data2_in = '0; rd_in = '0;
    Branch_in = 0; MemRead_in = 0; MemtoReg_in = 0; MemWrite_in = 0;
    RegWrite_in = 0; zero_in = 0; mem_ack = 0;
  endtask

  initial begin
    clear_inputs();
    mem_rdata = '0;
    // Reset held 2 cycles with a pending load
    reset = 1; MemRead_in = 1; aluResult_in = 64'h100;
    step(); step();
    check("rst_readData", readData_out, 0);
    check("rst_aluResult", aluResult_out, 0);
    check("rst_rd", rd_out, 0);
    check("rst_regwrite", RegWrite_out, 0);
    check("rst_memtoreg", MemtoReg_out, 0);
    check("rst_err", mem_err, 0);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_stall", stall, 0);
    reset = 0; #1;
    check("post_rst_stall", stall, 1);
    check("post_rst_req", mem_req, 0);
    step();
    check("post_rst_req_rise", mem_req, 1);
    check("post_rst_addr", mem_addr, 64'h100);
    // Reset wins over an ack on the same edge
    reset = 1; mem_ack = 1; MemRead_in = 0; mem_rdata = 64'hDEADBEEF;
    step();
    check("rst_ack_req", mem_req, 0);
    check("rst_ack_readData", readData_out, 0);
    reset = 0; clear_inputs();
    step();

    // R-type pass-through
    aluResult_in = 64'h1234; rd_in = 7; RegWrite_in = 1; #1;
    check("rtype_stall", stall, 0);
    step();
    check("rtype_alu", aluResult_out, 64'h1234);
    check("rtype_rd", rd_out, 7);
    check("rtype_regwrite", RegWrite_out, 1);
    check("rtype_stall2", stall, 0);

    // Load, ack in the third REQ cycle
    clear_inputs();
    aluResult_in = 64'h100; MemRead_in = 1; MemtoReg_in = 1; rd_in = 5;
    RegWrite_in = 1; mem_rdata = 64'hDEADBEEF; #1;
    check("ld_stall_idle", stall, 1);
    step();
    check("ld_req1", mem_req, 1);
    check("ld_addr", mem_addr, 64'h100);
    check("ld_we", mem_we, 0);
    check("ld_stall_r1", stall, 1);
    check("ld_bubble_regwrite", RegWrite_out, 0);
    check("ld_bubble_alu", aluResult_out, 0);
    Branch_in = 1; zero_in = 1; #1;
    check("ld_pcsrc_req", PCSrc, 0);
    Branch_in = 0; zero_in = 0;
    step();
    check("ld_stall_r2", stall, 1);
    step();
    mem_ack = 1; #1;
    check("ld_stall_ack", stall, 0);
    step();
    clear_inputs();
    check("ld_readData", readData_out, 64'hDEADBEEF);
    check("ld_rd", rd_out, 5);
    check("ld_regwrite", RegWrite_out, 1);
    check("ld_memtoreg", MemtoReg_out, 1);
    check("ld_alu", aluResult_out, 64'h100);
    check("ld_req_done", mem_req, 0);

    // Store, ack in the first REQ cycle
    aluResult_in = 64'h80; data2_in = 64'h55; MemWrite_in = 1; rd_in = 3; #1;
    check("st_stall_idle", stall, 1);
    step();
    check("st_we", mem_we, 1);
    check("st_wdata", mem_wdata, 64'h55);
    check("st_addr", mem_addr, 64'h80);
    mem_ack = 1; #1;
    check("st_stall_ack", stall, 0);
    step();
    clear_inputs();
    check("st_readData", readData_out, 0);
    check("st_regwrite", RegWrite_out, 0);
    check("st_req_done", mem_req, 0);

    // Read and write both set: treated as a write, read data discarded
    aluResult_in = 64'h90; data2_in = 64'h66; MemRead_in = 1; MemWrite_in = 1;
    RegWrite_in = 1; mem_rdata = 64'hAAAA;
    step();
    check("rw_we", mem_we, 1);
    mem_ack = 1;
    step();
    clear_inputs();
    check("rw_readData", readData_out, 0);

    // Timeout with no ack
    aluResult_in = 64'h200; MemRead_in = 1; rd_in = 9; RegWrite_in = 1;
    step();
    n = 0;
    while (mem_req && n < 20) begin
      n++;
      if (n == 4) begin
        check("to_stall_last", stall, 0);
        check("to_err_before", mem_err, 0);
        clear_inputs();
        aluResult_in = 64'h77; rd_in = 2; RegWrite_in = 1;
      end
      step();
    end
    check("to_req_cycles", n, 4);
    check("to_err", mem_err, 1);
    check("to_bubble_regwrite", RegWrite_out, 0);
    check("to_bubble_rd", rd_out, 0);
    step();
    check("to_next_alu", aluResult_out, 64'h77);
    check("to_next_rd", rd_out, 2);
    check("to_next_regwrite", RegWrite_out, 1);
    check("to_err_sticky", mem_err, 1);

    // Branch taken in IDLE
    clear_inputs();
    Branch_in = 1; zero_in = 1; PC_in = 64'h40; #1;
    check("br_pcsrc", PCSrc, 1);
    check("br_target", branch_target, 64'h40);
    step();
    clear_inputs();
    // Stray ack in IDLE
    aluResult_in = 64'h33; rd_in = 4; RegWrite_in = 1; mem_ack = 1; mem_rdata = 64'hFFFF;
    step();
    check("stray_req", mem_req, 0);
    check("stray_readData", readData_out, 0);
    check("stray_alu", aluResult_out, 64'h33);
    check("stray_stall", stall, 0);

    // Reset clears the sticky error
    mem_ack = 0; reset = 1;
    step();
    reset = 0;
    check("rst_err_clear", mem_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
